// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for one shared memory: latches the winning request, waits out the read latency, acks once.
// Write acks 2 cycles after the request is sampled, reads 2+READ_LATENCY; one transaction in flight at a time.
module mem_port_arbiter #(
  parameter int N            = 32,
  parameter int READ_LATENCY = 1,
  parameter bit RR_EN        = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic         p0_we,
  input  logic [N-1:0] p0_addr,
  input  logic [N-1:0] p0_wdata,
  output logic         p0_ack,
  input  logic         p1_req,
  input  logic         p1_we,
  input  logic [N-1:0] p1_addr,
  input  logic [N-1:0] p1_wdata,
  output logic         p1_ack,
  output logic [N-1:0] rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata,
  output logic         busy,
  output logic         grant_id
);

  localparam logic [1:0] RL = 2'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t       state, state_nxt;
  logic [1:0]   cnt;
  logic         we_q;
  logic         grant_q;
  logic [N-1:0] addr_q, wdata_q, rdata_q;
  logic         win;

  // On a tie, round-robin hands the grant to the port that did not own the last transaction.
  always_comb begin
    win = 1'b0;
    if (p0_req && p1_req) win = RR_EN ? ~grant_q : 1'b0;
    else                  win = p1_req;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (p0_req || p1_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_we = we_q;
        if (we_q || cnt == RL) state_nxt = DONE;
      end
      DONE: begin
        p0_ack    = ~grant_q;
        p1_ack    = grant_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      we_q    <= 1'b0;
      grant_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant_q <= win;
            we_q    <= win ? p1_we    : p0_we;
            addr_q  <= win ? p1_addr  : p0_addr;
            wdata_q <= win ? p1_wdata : p0_wdata;
            cnt     <= 2'd0;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (cnt == RL) rdata_q <= mem_rdata;
            else           cnt     <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;

endmodule
